// File: rtl/muldiv_sequencer_if.sv
// Handshake bundle between the main control FSM (master) and the multiply/divide
// sequencer (slave): start requests in, step/write/exception strobes out.
interface muldiv_sequencer_if;
   logic       mult_start;
   logic       div_start;
   logic       Div0;
   logic       busy;
   logic       load_ops;
   logic       mult_step;
   logic       div_step;
   logic [5:0] iter_count;
   logic       sign_fix;
   logic       WriteHI;
   logic       WriteLO;
   logic       done;
   logic       div0_exc;

   modport master (
      output mult_start, div_start, Div0,
      input  busy, load_ops, mult_step, div_step, iter_count,
             sign_fix, WriteHI, WriteLO, done, div0_exc
   );

   modport slave (
      input  mult_start, div_start, Div0,
      output busy, load_ops, mult_step, div_step, iter_count,
             sign_fix, WriteHI, WriteLO, done, div0_exc
   );
endinterface

// File: rtl/muldiv_sequencer.sv
// Moore sequencer that walks the datapath through a 32-iteration multiply or divide.
// Define MULDIV_SIGN_FIX_EN to insert a one-cycle signed-correction state after divides.
module muldiv_sequencer (
   input logic              i_clock,
   input logic              i_reset_n,
   muldiv_sequencer_if.slave bus
);

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      MULT,
      DIV,
`ifdef MULDIV_SIGN_FIX_EN
      FIX,
`endif
      WRITE,
      EXC
   } state_t;

   state_t     r_state;
   logic       r_isDiv;
   logic [5:0] r_iter;
   logic       r_busy;
   logic       r_load;
   logic       r_multStep;
   logic       r_divStep;
   logic       r_write;
   logic       r_exc;
`ifdef MULDIV_SIGN_FIX_EN
   logic       r_signFix;
`endif

   // Every output is set on the edge that enters the state it belongs to, so outputs
   // line up with the state without any combinational decode.
   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_state    <= IDLE;
         r_isDiv    <= 1'b0;
         r_iter     <= 6'd0;
         r_busy     <= 1'b0;
         r_load     <= 1'b0;
         r_multStep <= 1'b0;
         r_divStep  <= 1'b0;
         r_write    <= 1'b0;
         r_exc      <= 1'b0;
`ifdef MULDIV_SIGN_FIX_EN
         r_signFix  <= 1'b0;
`endif
      end else begin
         r_load  <= 1'b0;
         r_write <= 1'b0;
         r_exc   <= 1'b0;
`ifdef MULDIV_SIGN_FIX_EN
         r_signFix <= 1'b0;
`endif
         case (r_state)
            IDLE: begin
               // Multiply has priority; a simultaneous divide request is simply dropped.
               if (bus.mult_start) begin
                  r_state <= LOAD;
                  r_isDiv <= 1'b0;
                  r_busy  <= 1'b1;
                  r_load  <= 1'b1;
               end else if (bus.div_start) begin
                  r_busy <= 1'b1;
                  if (bus.Div0) begin
                     r_state <= EXC;
                     r_exc   <= 1'b1;
                  end else begin
                     r_state <= LOAD;
                     r_isDiv <= 1'b1;
                     r_load  <= 1'b1;
                  end
               end
            end
            LOAD: begin
               r_iter <= 6'd0;
               if (r_isDiv) begin
                  r_state   <= DIV;
                  r_divStep <= 1'b1;
               end else begin
                  r_state    <= MULT;
                  r_multStep <= 1'b1;
               end
            end
            MULT: begin
               if (r_iter == 6'd31) begin
                  r_iter     <= 6'd0;
                  r_multStep <= 1'b0;
                  r_state    <= WRITE;
                  r_write    <= 1'b1;
               end else begin
                  r_iter <= r_iter + 6'd1;
               end
            end
            DIV: begin
               if (r_iter == 6'd31) begin
                  r_iter    <= 6'd0;
                  r_divStep <= 1'b0;
`ifdef MULDIV_SIGN_FIX_EN
                  r_state   <= FIX;
                  r_signFix <= 1'b1;
`else
                  r_state   <= WRITE;
                  r_write   <= 1'b1;
`endif
               end else begin
                  r_iter <= r_iter + 6'd1;
               end
            end
`ifdef MULDIV_SIGN_FIX_EN
            FIX: begin
               r_state <= WRITE;
               r_write <= 1'b1;
            end
`endif
            WRITE: begin
               r_state <= IDLE;
               r_isDiv <= 1'b0;
               r_busy  <= 1'b0;
            end
            EXC: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
            end
            default: begin
               r_state    <= IDLE;
               r_isDiv    <= 1'b0;
               r_iter     <= 6'd0;
               r_busy     <= 1'b0;
               r_multStep <= 1'b0;
               r_divStep  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.busy       = r_busy;
   assign bus.load_ops   = r_load;
   assign bus.mult_step  = r_multStep;
   assign bus.div_step   = r_divStep;
   assign bus.iter_count = r_iter;
   assign bus.WriteHI    = r_write;
   assign bus.WriteLO    = r_write;
   assign bus.done       = r_write;
   assign bus.div0_exc   = r_exc;
`ifdef MULDIV_SIGN_FIX_EN
   assign bus.sign_fix   = r_signFix;
`else
   assign bus.sign_fix   = 1'b0;
`endif

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: checks every output on every cycle of each
// scenario against a hand-derived cycle timeline.
module tb_muldiv_sequencer;

`ifdef MULDIV_SIGN_FIX_EN
   localparam bit SIGN_FIX = 1'b1;
`else
   localparam bit SIGN_FIX = 1'b0;
`endif

   logic clock;
   logic resetN;
   int   total;
   int   bad;

   muldiv_sequencer_if bus ();

   muldiv_sequencer dut (
      .i_clock   (clock),
      .i_reset_n (resetN),
      .bus       (bus.slave)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Safety net so the run always ends even if the stimulus stalls.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Observation vector: {busy, load_ops, mult_step, div_step, sign_fix,
   //                      WriteHI, WriteLO, done, div0_exc, iter_count[5:0]}
   function automatic logic [14:0] observe();
      return {bus.busy, bus.load_ops, bus.mult_step, bus.div_step, bus.sign_fix,
              bus.WriteHI, bus.WriteLO, bus.done, bus.div0_exc, bus.iter_count};
   endfunction

   // Expected outputs n cycles after a start is accepted (kind 0 = multiply, 1 = divide).
   function automatic logic [14:0] expectAt(int kind, int n);
      logic [14:0] e;
      int          writeN;
      e      = '0;
      writeN = (kind == 1 && SIGN_FIX) ? 35 : 34;
      if (n >= 1 && n <= writeN) e[14] = 1'b1;
      if (n == 1) e[13] = 1'b1;
      if (n >= 2 && n <= 33) begin
         if (kind == 0) e[12] = 1'b1;
         else           e[11] = 1'b1;
         e[5:0] = 6'(n - 2);
      end
      if (kind == 1 && SIGN_FIX && n == 34) e[10] = 1'b1;
      if (n == writeN) begin
         e[9] = 1'b1;
         e[8] = 1'b1;
         e[7] = 1'b1;
      end
      return e;
   endfunction

   task automatic applyStimulus(input logic m, input logic d, input logic z);
      bus.mult_start = m;
      bus.div_start  = d;
      bus.Div0       = z;
   endtask

   task automatic checkOutput(input string tag, input logic [14:0] observed,
                              input logic [14:0] expected);
      total++;
      assert (observed === expected)
      else begin
         bad++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic stepClock();
      @(posedge clock);
      #1;
   endtask

   // Checks cycles firstN..lastN of an operation; optionally pulses div_start at injectAt.
   task automatic runOp(input string tag, input int kind, input int firstN,
                        input int lastN, input int injectAt);
      for (int n = firstN; n <= lastN; n++) begin
         if (n == injectAt) applyStimulus(1'b0, 1'b1, 1'b0);
         checkOutput($sformatf("%s@%0d", tag, n), observe(), expectAt(kind, n));
         stepClock();
         applyStimulus(1'b0, 1'b0, 1'b0);
      end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      applyStimulus(1'b0, 1'b0, 1'b0);
      resetN = 1'b0;

      // Reset state, then a start accepted on the very first edge after release.
      stepClock();
      checkOutput("reset_state", observe(), 15'd0);
      @(negedge clock);
      resetN = 1'b1;
      applyStimulus(1'b1, 1'b0, 1'b0);
      stepClock();
      applyStimulus(1'b0, 1'b0, 1'b0);
      runOp("mult", 0, 1, 36, -1);

      // Divide with a nonzero divisor.
      applyStimulus(1'b0, 1'b1, 1'b0);
      stepClock();
      applyStimulus(1'b0, 1'b0, 1'b0);
      runOp("div", 1, 1, 37, -1);

      // Divide-by-zero goes straight to the exception pulse, then a multiply at cycle 2.
      applyStimulus(1'b0, 1'b1, 1'b1);
      stepClock();
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("div0_exc@1", observe(), 15'h4040);
      stepClock();
      applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput("div0_idle@2", observe(), 15'd0);
      stepClock();
      applyStimulus(1'b0, 1'b0, 1'b0);
      runOp("after_exc", 0, 1, 35, -1);

      // Simultaneous starts: multiply wins; a later divide request is ignored.
      applyStimulus(1'b1, 1'b1, 1'b0);
      stepClock();
      applyStimulus(1'b0, 1'b0, 1'b0);
      runOp("both", 0, 1, 36, 10);

      // Asynchronous reset in the middle of a divide.
      applyStimulus(1'b0, 1'b1, 1'b0);
      stepClock();
      applyStimulus(1'b0, 1'b0, 1'b0);
      runOp("div_abort", 1, 1, 16, -1);
      checkOutput("div_abort@17", observe(), expectAt(1, 17));
      #2;
      resetN = 1'b0;
      #1;
      checkOutput("async_reset_now", observe(), 15'd0);
      stepClock();
      checkOutput("async_reset_held", observe(), 15'd0);
      @(negedge clock);
      resetN = 1'b1;
      applyStimulus(1'b1, 1'b0, 1'b0);
      stepClock();
      applyStimulus(1'b0, 1'b0, 1'b0);
      runOp("post_reset", 0, 1, 35, -1);

      // Back-to-back: a new multiply in the first IDLE cycle after done.
      applyStimulus(1'b1, 1'b0, 1'b0);
      stepClock();
      applyStimulus(1'b0, 1'b0, 1'b0);
      runOp("b2b_first", 0, 1, 34, -1);
      applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput("b2b_idle@35", observe(), 15'd0);
      stepClock();
      applyStimulus(1'b0, 1'b0, 1'b0);
      runOp("b2b_second", 0, 1, 36, -1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
